// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: FSM state encoding, access-length codes,
// the default I/O region selector and a length-to-byte-count helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd2;

  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  // Code 3 is not a real length; it behaves as a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 3'd1;
      LEN_H:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store onto
// an 8-bit RAM/UART bus. Define MEM_CTRL_IO_WAIT_EN to stall I/O-region writes on UART full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_SEL = IO_SEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_inst_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i,
  input  logic              io_buffer_full_i,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic              sel_mem_q, sel_mem_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [ADDR_W-1:0] cur_a;
  logic              io_stall;

  assign cur_a = base_q + ADDR_W'(k_q);

`ifdef MEM_CTRL_IO_WAIT_EN
  assign io_stall = (cur_a[17:16] == IO_SEL) && io_buffer_full_i;
`else
  logic unused_io;
  assign io_stall  = 1'b0;
  assign unused_io = ^{io_buffer_full_i, IO_SEL};
`endif

  assign if_inst_o   = inst_q;
  assign mem_rdata_o = rdata_q;
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    base_d     = base_q;
    we_d       = we_q;
    sel_mem_d  = sel_mem_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    inst_d     = inst_q;
    rdata_d    = rdata_q;
    ram_a_o    = '0;
    ram_dout_o = '0;
    ram_wr_o   = 1'b0;
    if_done_o  = 1'b0;
    mem_done_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req_i || if_req_i) begin
          k_d       = 3'd0;
          asm_d     = '0;
          sel_mem_d = mem_req_i;
          if (mem_req_i) begin
            base_d  = mem_addr_i;
            n_d     = len_bytes(mem_len_i);
            we_d    = mem_we_i;
            wdata_d = mem_wdata_i;
          end else begin
            base_d  = if_addr_i;
            n_d     = 3'd4;
            we_d    = 1'b0;
          end
          state_d = we_d ? WRITE : READ;
        end
      end

      READ: begin
        if (k_q < n_q) ram_a_o = cur_a;
        // RAM answers one cycle late, so cycle k carries byte k-1.
        for (int b = 0; b < 4; b++) begin
          if (k_q == 3'(b + 1)) asm_d[8*b +: 8] = ram_din_i;
        end
        if (k_q == n_q) begin
          state_d = DONE;
          if (sel_mem_q) rdata_d = asm_d;
          else           inst_d  = asm_d;
        end else begin
          k_d = k_q + 3'd1;
        end
      end

      WRITE: begin
        ram_a_o = cur_a;
        for (int b = 0; b < 4; b++) begin
          if (k_q[1:0] == 2'(b)) ram_dout_o = wdata_q[8*b +: 8];
        end
        if (!io_stall) begin
          ram_wr_o = 1'b1;
          if (k_q == n_q - 3'd1) state_d = DONE;
          else                   k_d     = k_q + 3'd1;
        end
      end

      DONE: begin
        if_done_o  = !sel_mem_q;
        mem_done_o = sel_mem_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      n_q       <= '0;
      base_q    <= '0;
      we_q      <= 1'b0;
      sel_mem_q <= 1'b0;
      wdata_q   <= '0;
      asm_q     <= '0;
      inst_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      n_q       <= n_d;
      base_q    <= base_d;
      we_q      <= we_d;
      sel_mem_q <= sel_mem_d;
      wdata_q   <= wdata_d;
      asm_q     <= asm_d;
      inst_q    <= inst_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of all address ports.
REQ-002 SHALL have parameter IO_SEL, default 2'b11: value of addr[17:16] that marks the I/O region.
REQ-003 SHALL have port clk  in  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-005 SHALL have port if_req_i  in  1: instruction fetch requests a word read (level, held until done).
REQ-006 SHALL have port if_addr_i  in  ADDR_W: fetch address.
REQ-007 SHALL have port if_inst_o  out  32: fetched word, valid while if_done_o=1.
REQ-008 SHALL have port if_done_o  out  1: fetch complete, one-cycle pulse.
REQ-009 SHALL have port mem_req_i  in  1: load/store stage requests an access (level, held until done).
REQ-010 SHALL have port mem_we_i  in  1: 1=store, 0=load.
REQ-011 SHALL have port mem_len_i  in  2: access length; 0=byte, 1=half, 2=word, 3 treated as word.
REQ-012 SHALL have port mem_addr_i  in  ADDR_W: load/store address.
REQ-013 SHALL have port mem_wdata_i  in  32: store data, byte 0 in bits [7:0].
REQ-014 SHALL have port mem_rdata_o  out  32: load result, zero-extended, valid while mem_done_o=1.
REQ-015 SHALL have port mem_done_o  out  1: load/store complete, one-cycle pulse.
REQ-016 SHALL have port ram_a_o  out  ADDR_W: byte address to external RAM/UART bus.
REQ-017 SHALL have port ram_dout_o  out  8: write byte.
REQ-018 SHALL have port ram_wr_o  out  1: 1=write this cycle.
REQ-019 SHALL have port ram_din_i  in  8: read byte, returned one cycle after its address.
REQ-020 SHALL have port io_buffer_full_i  in  1: UART transmit buffer full.
REQ-021 SHALL have port busy_o  out  1: high in any state other than IDLE.

Function
REQ-022 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-023 In IDLE, mem_req_i SHALL win over if_req_i when both are high; the granted requester's address, length, data and we are latched on the accepting edge.
REQ-024 A fetch SHALL be a 4-byte read.
REQ-025 A load SHALL be an n-byte read, where n is 1, 2 or 4 from mem_len_i.
REQ-026 A store SHALL be an n-byte write.
REQ-027 On acceptance with byte counter k=0, the FSM SHALL go to READ or WRITE.
REQ-028 READ SHALL last n+1 cycles.
REQ-029 In READ cycle k (k<n), ram_a_o SHALL equal base+k with ram_wr_o=0.
REQ-030 In READ cycles k>=1, ram_din_i SHALL be captured into byte k-1, little-endian.
REQ-031 After the capture at k=n, the FSM SHALL go to DONE.
REQ-032 WRITE SHALL last n cycles: in cycle k, ram_a_o=base+k, ram_dout_o=wdata byte k, ram_wr_o=1; after k=n-1 the FSM goes to DONE.
REQ-033 DONE SHALL last exactly 1 cycle and assert the done_o of the granted requester, then return to IDLE.
REQ-034 Requesters SHALL deassert req in the cycle they see done; the FSM never re-accepts in DONE.
REQ-035 Latency, counted from the IDLE accept cycle (cycle 0): read done at cycle n+2; write done at cycle n+1.
REQ-036 Unused upper bytes of mem_rdata_o SHALL be 0.
REQ-037 Both data outputs SHALL hold their last value outside DONE.
REQ-038 In IDLE and DONE, ram_a_o=0, ram_dout_o=0 and ram_wr_o=0.
REQ-039 Address wrap SHALL be modulo 2^ADDR_W.
REQ-040 Request changes after acceptance SHALL be ignored until IDLE.

Reset
REQ-041 When rst=1 at an edge, the FSM SHALL go to IDLE with k=0, and all outputs SHALL be 0 from the next cycle, including mid-transfer.
REQ-042 An aborted transfer SHALL NOT produce done; requesters reissue.

Configuration
REQ-043 With MEM_CTRL_IO_WAIT_EN defined, a WRITE cycle whose address has addr[17:16]==IO_SEL SHALL stall while io_buffer_full_i=1: ram_wr_o=0, k frozen, ram_a_o held; it resumes the cycle after the flag clears.
REQ-044 Without MEM_CTRL_IO_WAIT_EN, io_buffer_full_i SHALL be ignored.

Structure
REQ-045 State encodings, length codes (LEN_B/LEN_H/LEN_W) and the IO_SEL default SHALL live in the shared defines file.
REQ-046 The block SHALL be a single module with no sub-module; the FSM, counter and byte-assembly register are inline.

Verification
REQ-047 Fetch: if_req=1, addr 0x100, RAM bytes 13,00,00,93 -> ram_a 0x100..0x103; if_inst=0x93000013 with if_done at cycle 6.
REQ-048 Store word: mem_req, we=1, len=2, addr 0x200, wdata 0xDEADBEEF -> wr bytes EF,BE,AD,DE at 0x200..0x203 in cycles 1-4; mem_done at cycle 5.
REQ-049 Load half: addr 0x2, RAM bytes 0xFF,0x80 -> mem_rdata=0x000080FF with mem_done at cycle 4.
REQ-050 Contention: if_req and mem_req both rise in the same IDLE cycle -> mem served first; fetch begins the IDLE cycle after the mem DONE.
REQ-051 Reset abort: rst pulsed in WRITE k=1 -> ram_wr=0 the next cycle; no done; state IDLE.
REQ-052 With MEM_CTRL_IO_WAIT_EN: byte store to 0x30000 with io_buffer_full high for 3 cycles -> ram_wr is held low for 3 cycles, then writes once; mem_done follows.
